// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_seq block.
//   alu_op_e    : 4-bit operation encodings (1001..1111 are illegal)
//   alu_state_e : control state (IDLE, MUL)
//   alu_flags_t : registered status flags
//   MUL_OP      : encoding of the iterative multiply
//   op_is_legal : 1 for encodings 0000..1000
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS_B = 4'b0000,
    OP_LSL    = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_AND    = 4'b0100,
    OP_OR     = 4'b0101,
    OP_XOR    = 4'b0110,
    OP_LSR    = 4'b0111,
    OP_MUL    = 4'b1000
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry_out;
    logic illegal;
  } alu_flags_t;

  localparam logic [3:0] MUL_OP = 4'b1000;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= MUL_OP);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of alu_seq.
//   Request  : in_valid, in_ready, A, B, op
//   Response : out_valid, out_ready, result, negative, zero, overflow,
//              carry_out, illegal
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. A producer holding valid keeps its payload stable until
// the transfer; ready may depend on state but never on the valid it faces.
// master = the requester/consumer (pipeline), slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             illegal;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow,
           carry_out, illegal
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow,
           carry_out, illegal
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: low WIDTH bits of unsigned A*B.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load operands (one-cycle pulse)
//   A, B         : operands, sampled on start
//   done         : high during the final step; product is valid with it
//   product      : accumulator including the final step's partial product
// One multiplier bit is consumed per cycle, so done rises WIDTH cycles
// after start and the caller registers product on that same edge.
module alu_mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST_STEP = (SHW + 1)'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW:0]     cnt;
  logic             busy;

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    product  = acc_next;
    done     = busy && (cnt == LAST_STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU for the EX stage: pass-B, LSL, add, sub, and, or, xor,
// LSR in one cycle; MUL iterates for WIDTH cycles with in_ready low.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : alu_seq_if slave (request, response, flags)
//   dbg_state    : current control state
// Result and flags live in an output register that holds while the
// consumer stalls; the state machine only gates new requests.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_seq_if.slave   bus,
  output alu_state_e dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flags_q;

  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // Combinational single-cycle datapath
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   lsl_w;
  logic [WIDTH:0]   lsr_w;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             cy_d;
  logic             ill_d;
  alu_flags_t       flags_d;
  alu_flags_t       mul_flags;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (bus.op == MUL_OP);

  always_comb begin
    amt   = bus.B[SHW-1:0];
    nb    = ~bus.B;
    // The extra bit above the MSB (LSL) or below the LSB (LSR) catches the
    // last bit shifted out; with amt = 0 it is the inserted zero.
    lsl_w = {1'b0, bus.A} << amt;
    lsr_w = {bus.A, 1'b0} >> amt;
    add_w = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w = {1'b0, bus.A} + {1'b0, nb} + (WIDTH + 1)'(1);
  end

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    cy_d  = 1'b0;
    ill_d = !op_is_legal(bus.op);
    case (bus.op)
      OP_PASS_B: res_d = bus.B;
      OP_LSL: begin
        res_d = lsl_w[WIDTH-1:0];
        cy_d  = lsl_w[WIDTH];
      end
      OP_ADD: begin
        res_d = add_w[WIDTH-1:0];
        cy_d  = add_w[WIDTH];
        // carry into the MSB recovered from the MSB sum bit
        ovf_d = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1] ^ add_w[WIDTH-1]) ^ add_w[WIDTH];
      end
      OP_SUB: begin
        res_d = sub_w[WIDTH-1:0];
        cy_d  = sub_w[WIDTH];
        ovf_d = (bus.A[WIDTH-1] ^ nb[WIDTH-1] ^ sub_w[WIDTH-1]) ^ sub_w[WIDTH];
      end
      OP_AND: res_d = bus.A & bus.B;
      OP_OR:  res_d = bus.A | bus.B;
      OP_XOR: res_d = bus.A ^ bus.B;
      OP_LSR: begin
        res_d = lsr_w[WIDTH:1];
        cy_d  = lsr_w[0];
      end
      default: res_d = '0; // MUL goes through the multiplier; illegal is 0
    endcase
    flags_d.negative  = res_d[WIDTH-1];
    flags_d.zero      = (res_d == '0);
    flags_d.overflow  = ovf_d;
    flags_d.carry_out = cy_d;
    flags_d.illegal   = ill_d;
  end

  always_comb begin
    mul_flags           = '0;
    mul_flags.negative  = mul_product[WIDTH-1];
    mul_flags.zero      = (mul_product == '0);
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && is_mul),
    .A       (bus.A),
    .B       (bus.B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_done)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !is_mul) begin
        res_q       <= res_d;
        flags_q     <= flags_d;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        // accept implies any pending output was consumed this edge
        out_valid_q <= 1'b0;
      end else if (state_q == MUL && mul_done) begin
        res_q       <= mul_product;
        flags_q     <= mul_flags;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.negative  = flags_q.negative;
  assign bus.zero      = flags_q.zero;
  assign bus.overflow  = flags_q.overflow;
  assign bus.carry_out = flags_q.carry_out;
  assign bus.illegal   = flags_q.illegal;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an 8-bit and a 64-bit instance, directed cases plus
// randomized traffic with random backpressure, scoreboarded against an
// arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  typedef logic [68:0] exp_t; // {result[63:0], neg, zero, ovf, carry, illegal}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(64)) b64 ();
  alu_state_e st8, st64;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(b8), .dbg_state(st8));
  alu_seq #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .bus(b64), .dbg_state(st64));

  // ---------------- scoreboard state ----------------
  exp_t exp_q8[$];
  exp_t exp_q64[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_rdy = 1'b0;
  bit   rdy_val  = 1'b1;

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit values masked to w bits.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0]  mask, a, b, r;
    logic [127:0] wide;
    logic [64:0]  s;
    int           amt;
    bit           ov, cy, il;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    amt = int'(b % 64'(w));
    r = '0; ov = 0; cy = 0; il = 0;
    case (op)
      4'd0: r = b;
      4'd1: begin
        wide = {64'd0, a} << amt;
        r = wide[63:0] & mask;
        cy = wide[w];
      end
      4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0] & mask;
        cy = s[w];
        ov = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'd3: begin
        r = (a - b) & mask;
        cy = (a >= b);
        ov = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin
        r = a >> amt;
        cy = (amt == 0) ? 1'b0 : a[amt-1];
      end
      4'd8: r = (a * b) & mask;
      default: il = 1;
    endcase
    return {r, r[w-1], (r == 64'd0), ov, cy, il};
  endfunction

  function automatic exp_t get8();
    return {56'd0, b8.result, b8.negative, b8.zero, b8.overflow, b8.carry_out, b8.illegal};
  endfunction

  function automatic exp_t get64();
    return {b64.result, b64.negative, b64.zero, b64.overflow, b64.carry_out, b64.illegal};
  endfunction

  // ---------------- out_ready driver ----------------
  initial begin
    b8.out_ready  = 1'b1;
    b64.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      b8.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  // ---------------- monitors ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && b8.out_valid) begin
        if (exp_q8.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out8_unexpected: got %h expected none", get8());
        end else begin
          check("out8", get8(), exp_q8[0]);
          if (b8.out_ready) void'(exp_q8.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && b64.out_valid) begin
        if (exp_q64.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out64_unexpected: got %h expected none", get64());
        end else begin
          check("out64", get64(), exp_q64[0]);
          if (b64.out_ready) void'(exp_q64.pop_front());
        end
      end
    end
  end

  // ---------------- request drivers ----------------
  task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    b8.in_valid = 1'b1; b8.op = op; b8.A = a; b8.B = b;
    while (!b8.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b8.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send8_timeout: got in_ready 0 expected 1");
      b8.in_valid = 1'b0;
      return;
    end
    exp_q8.push_back(model(8, op, {56'd0, a}, {56'd0, b}));
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
  endtask

  task automatic send64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int t = 0;
    @(negedge clk);
    b64.in_valid = 1'b1; b64.op = op; b64.A = a; b64.B = b;
    while (!b64.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b64.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send64_timeout: got in_ready 0 expected 1");
      b64.in_valid = 1'b0;
      return;
    end
    exp_q64.push_back(model(64, op, a, b));
    @(posedge clk);
    #1 b64.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((exp_q8.size() != 0 || exp_q64.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_t'(exp_q8.size() + exp_q64.size()), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int z;
    int seen;
    b8.in_valid = 1'b0;  b8.op = '0;  b8.A = '0;  b8.B = '0;
    b64.in_valid = 1'b0; b64.op = '0; b64.A = '0; b64.B = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_out8", get8(), '0);
    check("rst_out64", get64(), '0);
    check("rst_valid8", exp_t'(b8.out_valid), '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready8", exp_t'(b8.in_ready), 69'd1);
    check("rst_in_ready64", exp_t'(b64.in_ready), 69'd1);

    // 64-bit add overflow and subtract corner cases
    send64(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    send64(4'b0011, 64'd5, 64'd5);
    send64(4'b0011, 64'd0, 64'd1);
    send64(4'b0001, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFC1);
    send64(4'b0111, 64'h8000_0000_0000_0001, 64'd64);
    for (int i = 0; i < 8; i++)
      send64(4'($urandom_range(0, 9)), {$urandom, $urandom}, {$urandom, $urandom});
    drain(300);

    // 8-bit shifts: amount taken mod WIDTH, zero amount gives no carry
    send8(4'b0001, 8'h81, 8'h09);
    send8(4'b0111, 8'h81, 8'h00);
    send8(4'b0111, 8'h81, 8'h03);
    drain(50);

    // MUL latency: in_ready low for exactly WIDTH cycles
    send8(4'b1000, 8'd13, 8'd11);
    z = 0;
    @(negedge clk);
    while (!b8.in_ready && z < 50) begin
      z++;
      @(negedge clk);
    end
    check("mul_busy_cycles", exp_t'(z), 69'd8);
    drain(50);

    // reset in the middle of a MUL aborts it
    send8(4'b1000, 8'd200, 8'd77);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    exp_q8.delete();
    #1;
    check("mulrst_out8", get8(), '0);
    check("mulrst_state", exp_t'(st8), exp_t'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mulrst_in_ready", exp_t'(b8.in_ready), 69'd1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.out_valid) seen++;
    end
    check("mulrst_no_result", exp_t'(seen), '0);

    // backpressure: held output, in_ready low, then consume + accept together
    rdy_val = 1'b0;
    @(posedge clk);
    #2;
    send8(4'b0110, 8'hF0, 8'h0F);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", exp_t'(b8.in_ready), '0);
    end
    rdy_val = 1'b1;
    send8(4'b0100, 8'hF0, 8'h0F);
    @(negedge clk);
    check("bp_valid_cont", exp_t'(b8.out_valid), 69'd1);
    drain(50);

    // illegal encodings followed by pass-B
    send8(4'b1011, 8'($urandom), 8'($urandom));
    send8(4'b1111, 8'($urandom), 8'($urandom));
    send8(4'b0000, 8'h3C, 8'h55);
    send8(4'b0011, 8'h80, 8'h01);
    send8(4'b0010, 8'hFF, 8'h01);
    drain(50);

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_rdy = 1'b0;
    rdy_val  = 1'b1;
    drain(500);
    check("end_state8", exp_t'(st8), exp_t'(IDLE));
    check("end_state64", exp_t'(st64), exp_t'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
